// File: rtl/uart_pkg.sv
// Frame-format constants and FSM state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks.
// The sync clear lets the receiver align its bit timing to a start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, LSB first on an idle-high line.
// Emits a one-clock valid strobe per good byte or a one-clock framing_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 326
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  logic                 tick_clear;
  logic                 shift_en;
  logic                 load_data;
  logic                 set_ferr;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    tick_clear = 1'b0;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    set_ferr   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          tick_clear = 1'b1;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (tick && os_cnt == OS_MID) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && os_cnt == OS_LAST) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick && os_cnt == OS_LAST) begin
          if (rx_s) begin
            load_data  = 1'b1;
            state_next = IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      state       <= state_next;
      valid       <= load_data;
      framing_err <= set_ferr;
      if (state_next != state) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + OS_W'(1);
      end
      if (state == START && state_next == DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      // Bits arrive LSB first, so each new bit enters at the MSB end.
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
      if (load_data) begin
        data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames, compared
// against an expected-event queue built from the frame contents the bench sends.
module tb_uart_rx;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = CLK_DIV * 16;

  typedef struct {
    int         kind;
    logic [7:0] value;
    int         lo;
    int         hi;
  } event_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  event_t     exp_q[$];
  event_t     obs_q[$];
  int         cycle = 0;
  int         compare_count = 0;
  int         mismatch_count = 0;
  int         both_high = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] model_data;

  uart_rx #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Log every strobe with the clock it appeared on; kind 1 = good byte, 2 = framing error.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid) obs_q.push_back('{1, data, cycle, cycle});
      if (framing_err) obs_q.push_back('{2, data, cycle, cycle});
      if (valid && framing_err) both_high++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic level, input int clks);
    rx = level;
    repeat (clks) @(negedge clk);
  endtask

  // Sends one 8N1 frame; the expected strobe must land somewhere inside the stop bit.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int period);
    int stop_start;
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(value[i], period);
    stop_start = cycle;
    if (stop_bit) begin
      exp_q.push_back('{1, value, stop_start, stop_start + period});
      model_data = value;
    end else begin
      exp_q.push_back('{2, model_data, stop_start, stop_start + period});
    end
    drive_bit(stop_bit, period);
  endtask

  task automatic compare_events(input string tag);
    int n;
    checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      checkOutput({tag, "_value"}, obs_q[i].value, exp_q[i].value);
      checkOutput({tag, "_in_stop_bit"},
                  (obs_q[i].lo >= exp_q[i].lo) && (obs_q[i].lo <= exp_q[i].hi), 1);
    end
    checkOutput({tag, "_exclusive"}, both_high, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] partial;
    logic [7:0] rand_val;
    logic       rand_stop;
    int         rand_period;

    reset      = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_ferr", framing_err, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    drive_bit(1'b1, 20);

    applyStimulus(8'hA5, 1'b1, BIT_CLKS);
    drive_bit(1'b1, 40);
    checkOutput("t1_busy_after", busy, 0);
    compare_events("t1");
    checkOutput("t1_data", data, model_data);

    busy_seen = 1'b0;
    drive_bit(1'b0, 12);
    drive_bit(1'b1, 80);
    checkOutput("t2_busy_seen", busy_seen, 1);
    checkOutput("t2_busy_after", busy, 0);
    compare_events("t2");
    checkOutput("t2_data", data, model_data);

    applyStimulus(8'h3C, 1'b0, BIT_CLKS);
    drive_bit(1'b0, 200);
    checkOutput("t3_busy_break", busy, 1);
    drive_bit(1'b1, 40);
    checkOutput("t3_busy_after", busy, 0);
    compare_events("t3");
    checkOutput("t3_data", data, model_data);

    applyStimulus(8'h00, 1'b1, BIT_CLKS);
    applyStimulus(8'hFF, 1'b1, BIT_CLKS);
    drive_bit(1'b1, 40);
    compare_events("t4");
    checkOutput("t4_data", data, model_data);

    partial = 8'h55;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(partial[i], BIT_CLKS);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    model_data = 8'h00;
    checkOutput("t5_reset_data", data, 0);
    checkOutput("t5_reset_valid", valid, 0);
    checkOutput("t5_reset_ferr", framing_err, 0);
    checkOutput("t5_reset_busy", busy, 0);
    reset = 1'b0;
    drive_bit(1'b1, 100);
    compare_events("t5_abort");
    applyStimulus(8'h81, 1'b1, BIT_CLKS);
    drive_bit(1'b1, 40);
    compare_events("t5");
    checkOutput("t5_data", data, model_data);

    applyStimulus(8'h96, 1'b1, 62);
    drive_bit(1'b1, 40);
    applyStimulus(8'h96, 1'b1, 66);
    drive_bit(1'b1, 40);
    compare_events("t6");
    checkOutput("t6_data", data, model_data);

    for (int n = 0; n < 10; n++) begin
      rand_val    = 8'($urandom_range(0, 255));
      rand_stop   = ($urandom_range(0, 3) != 0);
      rand_period = $urandom_range(62, 66);
      applyStimulus(rand_val, rand_stop, rand_period);
      if (!rand_stop) begin
        drive_bit(1'b0, $urandom_range(20, 100));
        drive_bit(1'b1, 20);
      end
      drive_bit(1'b1, $urandom_range(0, 30));
    end
    drive_bit(1'b1, 40);
    compare_events("rand");
    checkOutput("rand_data", data, model_data);
    checkOutput("rand_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
